pipelined_adder: RTL and testbench
==================================

Name: pipelined_adder

Overview:
- Parametrised, pipelined add/subtract unit; successor to the team's fixed 4-bit registered adder.
- Splits a WIDTH-bit carry chain into STAGES registered segments so wide adds close timing at high clock rates.
- Valid/ready handshake on input and output; sits between operand-issue logic and result consumers in datapath blocks.
- Produces a true carry-out and a signed-overflow flag.

Parameters:
- WIDTH, 16, operand/result width in bits. WIDTH % STAGES == 0 is required, enforced by an elaboration-time assertion.
- STAGES, 4, number of pipeline segments; equals latency in cycles. Allowed range 1..WIDTH.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  unit accepts a beat this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in (add) / borrow-in (sub)
- sub  in  1  0 = add, 1 = subtract
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  result
- cout  out  1  carry-out (add) / not-borrow (sub)
- ovf  out  1  signed two's-complement overflow

Behaviour:
- Reset and clocking: reset is synchronous, active-high; clock is clk. On reset, all stage valid bits are cleared and out_valid, sum, cout and ovf all go to 0. Data registers may also clear. A reset mid-operation discards every in-flight beat; nothing is emitted afterwards.
- Operand preparation at acceptance: b_eff = sub ? ~b : b; c0 = sub ? ~cin : cin.
  - Add mode: result = a + b + cin.
  - Sub mode: result = a - b - cin; cout = 1 means no borrow.
- Segment slicing: SEG = WIDTH/STAGES. Stage k (k = 0..STAGES-1) adds bits [k*SEG +: SEG] of a and b_eff plus the carry registered by stage k-1 (stage 0 uses c0).
- Per-stage registers: stage k registers its SEG-bit partial sum and its carry. Lower partial sums and the unconsumed upper operand slices are carried forward in the stage registers.
- Outputs: sum is the concatenation of all partial sums. cout is the carry out of the top segment. ovf = (a_msb == b_eff_msb) && (sum_msb != a_msb), using the MSBs captured at acceptance.
- Latency: a beat accepted at edge N (in_valid && in_ready) presents out_valid = 1 after edge N+STAGES-1, when there are no stalls. With STAGES=1 the block behaves as a single registered adder with handshake.
- Throughput: one beat per cycle when out_ready is held high.
- Flow control: global enable adv = !out_valid || out_ready. in_ready = adv (combinational from out_valid and out_ready only; never depends on in_valid).
  - When adv = 1, every stage shifts forward one position and bubbles propagate as valid = 0.
  - When adv = 0, all stage registers hold.
- Output stability: sum, cout and ovf are stable while out_valid && !out_ready.
- Same-cycle accept and drain: accepting a beat while draining the output is legal and loses no data.
- Wrap-around: the sum wraps modulo 2^WIDTH, and the lost bit appears on cout. Example: 0xFFFF + 1 gives sum = 0x0000, cout = 1.
- Identical operands: a == b with sub = 1, cin = 0 gives sum = 0, cout = 1, ovf = 0.

Decomposition:
- Package pipelined_adder_pkg:
  - op_e enum {OP_ADD = 0, OP_SUB = 1}.
  - Function ovf_calc(a_msb, b_msb, s_msb).
- Sub-module adder_segment: one SEG-bit registered adder slice.
  - Inputs: clk, reset, en, valid_i, a_i, b_i, c_i.
  - Outputs: valid_o, s_o, c_o.
  - Instantiated STAGES times in a generate loop; the top level owns the operand and partial-sum delay lines.

Test Plan:
- Reset mid-stream: WIDTH=16, STAGES=4; issue 3 beats, assert reset for one cycle -> out_valid stays 0 for the next 8 cycles and in_ready = 1 after reset.
- Basic add latency: a=0x1234, b=0x0FCD, cin=0, sub=0 at edge 0 -> out_valid at edge 3 with sum=0x2201, cout=0, ovf=0.
- Carry across every segment: a=0xFFFF, b=0x0001 -> sum=0x0000, cout=1, ovf=0. Then a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1.
- Subtract with borrow: a=0x0005, b=0x0007, sub=1, cin=0 -> sum=0xFFFE, cout=0, ovf=0. Then a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, cout=1, ovf=1.
- Backpressure: stream 10 back-to-back beats while out_ready toggles at random -> in_ready=0 exactly when out_valid && !out_ready. All 10 results arrive in order, none dropped or duplicated, and outputs are held stable during stalls.
- Parameter sweep with a scoreboard: (WIDTH, STAGES) = (4,1), (8,2), (32,8), each with 1000 random beats including random cin and sub -> every result matches the reference-model sum, cout and ovf.

Source files
------------

// File: rtl/pipelined_adder_pkg.sv
// rtl/pipelined_adder_pkg.sv - shared types and helpers for the pipelined add/subtract unit
package pipelined_adder_pkg;

   // Operation select as presented on the sub input.
   typedef enum logic {
      OP_ADD = 1'b0,
      OP_SUB = 1'b1
   } op_e;

   // Signed overflow: operands agree in sign but the result does not.
   function automatic logic ovf_calc(input logic a_msb, input logic b_msb, input logic s_msb);
      return (a_msb == b_msb) && (s_msb != a_msb);
   endfunction

endpackage

// File: rtl/pipelined_adder_segment.sv
// rtl/pipelined_adder_segment.sv - one SEG-bit registered slice of the carry chain
module adder_segment
   import pipelined_adder_pkg::*;
#(
   parameter int SEG = 4
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           en,
   input  logic           valid_i,
   input  logic [SEG-1:0] a_i,
   input  logic [SEG-1:0] b_i,
   input  logic           c_i,
   output logic           valid_o,
   output logic [SEG-1:0] s_o,
   output logic           c_o
);

   logic           valid_q, valid_d;
   logic [SEG-1:0] s_q, s_d;
   logic           c_q, c_d;
   logic [SEG:0]   raw_sum;

   // Slice add; the whole slice holds its state when the pipeline is stalled.
   always_comb begin
      raw_sum = {1'b0, a_i} + {1'b0, b_i} + {{SEG{1'b0}}, c_i};
      valid_d = valid_q;
      s_d     = s_q;
      c_d     = c_q;
      if (en) begin
         valid_d = valid_i;
         s_d     = raw_sum[SEG-1:0];
         c_d     = raw_sum[SEG];
      end
   end

   // Slice state registers, cleared by reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         s_q     <= '0;
         c_q     <= 1'b0;
      end else begin
         valid_q <= valid_d;
         s_q     <= s_d;
         c_q     <= c_d;
      end
   end

   assign valid_o = valid_q;
   assign s_o     = s_q;
   assign c_o     = c_q;

endmodule

// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - parametrised pipelined add/subtract unit with valid/ready handshake
module pipelined_adder
   import pipelined_adder_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int SEG = WIDTH / STAGES;

   generate
      if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_bad_params
         $error("pipelined_adder: STAGES must be in 1..WIDTH and divide WIDTH");
      end
   endgenerate

   op_e              op;
   logic             adv;
   logic [WIDTH-1:0] b_eff;
   logic             c0;

   // Delay lines: full operand words ride along so the upper slices reach
   // their segment and the MSBs are still available for the overflow flag.
   logic [WIDTH-1:0] a_q    [STAGES];
   logic [WIDTH-1:0] a_d    [STAGES];
   logic [WIDTH-1:0] b_q    [STAGES];
   logic [WIDTH-1:0] b_d    [STAGES];
   logic [WIDTH-1:0] psum_q [STAGES];
   logic [WIDTH-1:0] psum_d [STAGES];

   logic             seg_v_in  [STAGES];
   logic [SEG-1:0]   seg_a_in  [STAGES];
   logic [SEG-1:0]   seg_b_in  [STAGES];
   logic             seg_c_in  [STAGES];
   logic             seg_valid [STAGES];
   logic [SEG-1:0]   seg_s     [STAGES];
   logic             seg_c     [STAGES];

   assign op        = op_e'(sub);
   assign b_eff     = (op == OP_SUB) ? ~b : b;
   assign c0        = (op == OP_SUB) ? ~cin : cin;

   assign out_valid = seg_valid[STAGES-1];
   assign adv       = !out_valid || out_ready;
   assign in_ready  = adv;

   // Feed each segment its operand slice and the carry of the segment below.
   always_comb begin
      for (int k = 0; k < STAGES; k++) begin
         seg_v_in[k] = 1'b0;
         seg_a_in[k] = '0;
         seg_b_in[k] = '0;
         seg_c_in[k] = 1'b0;
      end
      seg_v_in[0] = in_valid;
      seg_a_in[0] = a[SEG-1:0];
      seg_b_in[0] = b_eff[SEG-1:0];
      seg_c_in[0] = c0;
      for (int k = 1; k < STAGES; k++) begin
         seg_v_in[k] = seg_valid[k-1];
         seg_a_in[k] = a_q[k-1][k*SEG +: SEG];
         seg_b_in[k] = b_q[k-1][k*SEG +: SEG];
         seg_c_in[k] = seg_c[k-1];
      end
   end

   // Advance the operand and partial-sum delay lines in step with the segments.
   always_comb begin
      for (int k = 0; k < STAGES; k++) begin
         a_d[k]    = a_q[k];
         b_d[k]    = b_q[k];
         psum_d[k] = psum_q[k];
      end
      if (adv) begin
         a_d[0]    = a;
         b_d[0]    = b_eff;
         psum_d[0] = '0;
         for (int k = 1; k < STAGES; k++) begin
            a_d[k]    = a_q[k-1];
            b_d[k]    = b_q[k-1];
            psum_d[k] = psum_q[k-1] | (WIDTH'(seg_s[k-1]) << ((k-1) * SEG));
         end
      end
   end

   // Delay-line registers; reset clears them so outputs read zero after reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < STAGES; k++) begin
            a_q[k]    <= '0;
            b_q[k]    <= '0;
            psum_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            a_q[k]    <= a_d[k];
            b_q[k]    <= b_d[k];
            psum_q[k] <= psum_d[k];
         end
      end
   end

   generate
      for (genvar k = 0; k < STAGES; k++) begin : g_seg
         adder_segment #(
            .SEG (SEG)
         ) u_seg (
            .clk     (clk),
            .reset   (reset),
            .en      (adv),
            .valid_i (seg_v_in[k]),
            .a_i     (seg_a_in[k]),
            .b_i     (seg_b_in[k]),
            .c_i     (seg_c_in[k]),
            .valid_o (seg_valid[k]),
            .s_o     (seg_s[k]),
            .c_o     (seg_c[k])
         );
      end
   endgenerate

   // The top segment's sum is still inside its slice; merge it with the lower ones.
   assign sum  = psum_q[STAGES-1] | (WIDTH'(seg_s[STAGES-1]) << ((STAGES-1) * SEG));
   assign cout = seg_c[STAGES-1];
   assign ovf  = ovf_calc(a_q[STAGES-1][WIDTH-1], b_q[STAGES-1][WIDTH-1], sum[WIDTH-1]);

endmodule

// File: tb/tb_pipelined_adder.sv
// tb/tb_pipelined_adder.sv - self-checking bench for pipelined_adder
module tb_pipelined_adder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;
   int   n_tests = 0;
   int   n_fail  = 0;

   logic        m_iv, m_ir, m_cin, m_sub, m_ov, m_ordy, m_co, m_of;
   logic [15:0] m_a, m_b, m_sum;

   pipelined_adder #(.WIDTH(16), .STAGES(4)) u_main (
      .clk(clk), .reset(reset), .in_valid(m_iv), .in_ready(m_ir), .a(m_a), .b(m_b),
      .cin(m_cin), .sub(m_sub), .out_valid(m_ov), .out_ready(m_ordy), .sum(m_sum),
      .cout(m_co), .ovf(m_of));

   logic        sw_iv [3];
   logic        sw_cin[3];
   logic        sw_sub[3];
   logic        sw_ordy[3];
   logic [31:0] sw_a[3];
   logic [31:0] sw_b[3];
   logic        ir0, ov0, co0, of0, ir1, ov1, co1, of1, ir2, ov2, co2, of2;
   logic [3:0]  s0;
   logic [7:0]  s1;
   logic [31:0] s2;

   pipelined_adder #(.WIDTH(4), .STAGES(1)) u_w4 (
      .clk(clk), .reset(reset), .in_valid(sw_iv[0]), .in_ready(ir0), .a(sw_a[0][3:0]),
      .b(sw_b[0][3:0]), .cin(sw_cin[0]), .sub(sw_sub[0]), .out_valid(ov0),
      .out_ready(sw_ordy[0]), .sum(s0), .cout(co0), .ovf(of0));

   pipelined_adder #(.WIDTH(8), .STAGES(2)) u_w8 (
      .clk(clk), .reset(reset), .in_valid(sw_iv[1]), .in_ready(ir1), .a(sw_a[1][7:0]),
      .b(sw_b[1][7:0]), .cin(sw_cin[1]), .sub(sw_sub[1]), .out_valid(ov1),
      .out_ready(sw_ordy[1]), .sum(s1), .cout(co1), .ovf(of1));

   pipelined_adder #(.WIDTH(32), .STAGES(8)) u_w32 (
      .clk(clk), .reset(reset), .in_valid(sw_iv[2]), .in_ready(ir2), .a(sw_a[2]),
      .b(sw_b[2]), .cin(sw_cin[2]), .sub(sw_sub[2]), .out_valid(ov2),
      .out_ready(sw_ordy[2]), .sum(s2), .cout(co2), .ovf(of2));

   // Reference: integer arithmetic on unsigned and signed interpretations.
   function automatic void ref_add(input int w, input logic [31:0] a, input logic [31:0] b,
                                   input logic cin, input logic sub,
                                   output logic [31:0] s, output logic co, output logic ov);
      longint m, ua, ub, sa, sb, r, sr;
      m  = longint'(1) << w;
      ua = longint'({32'd0, a});
      ub = longint'({32'd0, b});
      sa = (ua >= m / 2) ? ua - m : ua;
      sb = (ub >= m / 2) ? ub - m : ub;
      if (sub) begin
         r  = ua - ub - longint'(cin);
         sr = sa - sb - longint'(cin);
         co = (r >= 0);
         if (r < 0) r = r + m;
      end else begin
         r  = ua + ub + longint'(cin);
         sr = sa + sb + longint'(cin);
         co = (r >= m);
         if (r >= m) r = r - m;
      end
      s  = 32'(r);
      ov = (sr < -(m / 2)) || (sr >= m / 2);
   endfunction

   task automatic get_sw(input int idx, output logic ir, output logic ov, output logic co,
                         output logic of, output logic [31:0] s);
      case (idx)
         0:       begin ir = ir0; ov = ov0; co = co0; of = of0; s = {28'd0, s0}; end
         1:       begin ir = ir1; ov = ov1; co = co1; of = of1; s = {24'd0, s1}; end
         default: begin ir = ir2; ov = ov2; co = co2; of = of2; s = s2; end
      endcase
   endtask

   task automatic test_reset();
      @(posedge clk);
      @(negedge clk);
      n_tests++;
      if ({m_ov, m_sum, m_co, m_of} !== 19'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got ov=%b sum=%h cout=%b ovf=%b, expected all zero", m_ov, m_sum, m_co, m_of);
      end
      reset = 1'b0;
      #1;
      n_tests++;
      if (m_ir !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_in_ready: got %b expected 1", m_ir);
      end
   endtask

   task automatic test_basic_latency();
      @(negedge clk);
      m_a = 16'h1234; m_b = 16'h0FCD; m_cin = 1'b0; m_sub = 1'b0; m_iv = 1'b1; m_ordy = 1'b1;
      for (int e = 0; e < 4; e++) begin
         @(posedge clk);
         @(negedge clk);
         m_iv = 1'b0;
         n_tests++;
         if (m_ov !== (e == 3)) begin
            n_fail++;
            $display("FAIL latency_edge%0d: out_valid got %b expected %b", e, m_ov, (e == 3));
         end
      end
      n_tests++;
      if ({m_sum, m_co, m_of} !== {16'h2201, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL basic_add: got sum=%h cout=%b ovf=%b expected 2201 0 0", m_sum, m_co, m_of);
      end
   endtask

   task automatic send_one(input logic [15:0] a, input logic [15:0] b, input logic cin,
                           input logic sub, output logic ok, output logic [15:0] s,
                           output logic co, output logic of);
      @(negedge clk);
      m_a = a; m_b = b; m_cin = cin; m_sub = sub; m_iv = 1'b1; m_ordy = 1'b1;
      @(posedge clk);
      @(negedge clk);
      m_iv = 1'b0;
      ok = 1'b0;
      s = 16'hxxxx; co = 1'bx; of = 1'bx;
      for (int i = 0; i < 20 && !ok; i++) begin
         if (m_ov) begin
            ok = 1'b1; s = m_sum; co = m_co; of = m_of;
         end else begin
            @(negedge clk);
         end
      end
   endtask

   typedef struct packed {
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic        sub;
      logic [15:0] s;
      logic        co;
      logic        of;
   } vec_t;

   task automatic test_directed();
      vec_t        v[7];
      logic        ok, co, of;
      logic [15:0] s;
      v = '{'{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0},
            '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1},
            '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0},
            '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1},
            '{16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0},
            '{16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0},
            '{16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b1, 1'b0}};
      for (int i = 0; i < 7; i++) begin
         send_one(v[i].a, v[i].b, v[i].cin, v[i].sub, ok, s, co, of);
         n_tests++;
         if (!ok || {s, co, of} !== {v[i].s, v[i].co, v[i].of}) begin
            n_fail++;
            $display("FAIL directed_%0d: got ok=%b sum=%h cout=%b ovf=%b expected sum=%h cout=%b ovf=%b",
                     i, ok, s, co, of, v[i].s, v[i].co, v[i].of);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [17:0] q[$];
      logic [17:0] exp_v, prev;
      logic [31:0] s32;
      logic        co, of, stall_prev, acc;
      int          sent, got;
      sent = 0; got = 0; stall_prev = 1'b0; acc = 1'b0; prev = '0;
      for (int cyc = 0; cyc < 300 && got < 10; cyc++) begin
         @(negedge clk);
         m_ordy = 1'($urandom_range(0, 1));
         if (acc) m_iv = 1'b0;
         if (sent < 10 && !m_iv) begin
            m_a = 16'($urandom); m_b = 16'($urandom);
            m_cin = 1'($urandom); m_sub = 1'($urandom); m_iv = 1'b1;
         end
         #1;
         if (stall_prev) begin
            n_tests++;
            if (m_ov !== 1'b1 || {m_co, m_of, m_sum} !== prev) begin
               n_fail++;
               $display("FAIL stall_hold: got ov=%b %h expected ov=1 %h", m_ov, {m_co, m_of, m_sum}, prev);
            end
         end
         n_tests++;
         if (m_ir !== (!m_ov || m_ordy)) begin
            n_fail++;
            $display("FAIL bp_in_ready: got %b expected %b", m_ir, (!m_ov || m_ordy));
         end
         if (m_ov && m_ordy) begin
            n_tests++;
            if (q.size() == 0) begin
               n_fail++;
               $display("FAIL bp_spurious: got an unexpected result %h expected none", m_sum);
            end else begin
               exp_v = q.pop_front();
               if ({m_co, m_of, m_sum} !== exp_v) begin
                  n_fail++;
                  $display("FAIL bp_result_%0d: got %h expected %h", got, {m_co, m_of, m_sum}, exp_v);
               end
            end
            got++;
         end
         acc = m_iv && m_ir;
         if (acc) begin
            ref_add(16, {16'd0, m_a}, {16'd0, m_b}, m_cin, m_sub, s32, co, of);
            q.push_back({co, of, s32[15:0]});
            sent++;
         end
         stall_prev = m_ov && !m_ordy;
         prev = {m_co, m_of, m_sum};
      end
      m_iv = 1'b0;
      n_tests++;
      if (got != 10 || sent != 10) begin
         n_fail++;
         $display("FAIL bp_count: got %0d results from %0d beats, expected 10 and 10", got, sent);
      end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         m_a = 16'($urandom); m_b = 16'($urandom); m_iv = 1'b1; m_ordy = 1'b1;
      end
      @(negedge clk);
      m_iv = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      #1;
      n_tests++;
      if (m_ir !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_reset_in_ready: got %b expected 1", m_ir);
      end
      for (int i = 0; i < 8; i++) begin
         n_tests++;
         if (m_ov !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_cycle%0d: out_valid got %b expected 0", i, m_ov);
         end
         @(negedge clk);
         #1;
      end
   endtask

   task automatic test_sweep(input int idx, input int w);
      logic [33:0] q[$];
      logic [33:0] exp_v;
      logic [31:0] mask, s, rs;
      logic        ir, ov, co, of, rco, rov, acc;
      int          sent, got;
      mask = 32'((longint'(1) << w) - 1);
      sent = 0; got = 0; acc = 1'b0;
      for (int cyc = 0; cyc < 20000 && got < 1000; cyc++) begin
         @(negedge clk);
         sw_ordy[idx] = ($urandom_range(0, 3) != 0);
         if (acc) sw_iv[idx] = 1'b0;
         if (sent < 1000 && !sw_iv[idx] && $urandom_range(0, 3) != 0) begin
            sw_a[idx] = $urandom & mask; sw_b[idx] = $urandom & mask;
            sw_cin[idx] = 1'($urandom); sw_sub[idx] = 1'($urandom); sw_iv[idx] = 1'b1;
         end
         #1;
         get_sw(idx, ir, ov, co, of, s);
         if (ov && sw_ordy[idx]) begin
            n_tests++;
            if (q.size() == 0) begin
               n_fail++;
               $display("FAIL sweep_w%0d_spurious: got %h expected none", w, s);
            end else begin
               exp_v = q.pop_front();
               if ({co, of, s} !== exp_v) begin
                  n_fail++;
                  $display("FAIL sweep_w%0d_beat%0d: got %h expected %h", w, got, {co, of, s}, exp_v);
               end
            end
            got++;
         end
         acc = sw_iv[idx] && ir;
         if (acc) begin
            ref_add(w, sw_a[idx], sw_b[idx], sw_cin[idx], sw_sub[idx], rs, rco, rov);
            q.push_back({rco, rov, rs});
            sent++;
         end
      end
      sw_iv[idx] = 1'b0;
      n_tests++;
      if (got != 1000) begin
         n_fail++;
         $display("FAIL sweep_w%0d_count: got %0d results expected 1000", w, got);
      end
   endtask

   initial begin
      reset = 1'b1;
      m_iv = 1'b0; m_a = '0; m_b = '0; m_cin = 1'b0; m_sub = 1'b0; m_ordy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         sw_iv[i] = 1'b0; sw_cin[i] = 1'b0; sw_sub[i] = 1'b0; sw_ordy[i] = 1'b0;
         sw_a[i] = '0; sw_b[i] = '0;
      end
      test_reset();
      test_basic_latency();
      test_directed();
      test_backpressure();
      test_reset_mid();
      test_sweep(0, 4);
      test_sweep(1, 8);
      test_sweep(2, 32);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
